pipe_control_unit: RTL and testbench



---
 rtl/pipe_control_unit_if.sv | 51 +++++
 rtl/pipe_control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_control_unit_if.sv
// Control-unit bus: ID-stage instruction fields and hazard inputs in,
// per-stage pipeline controls out. The master side is the pipeline/hazard
// logic, the slave side is the control unit.
interface pipe_control_unit_if #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 8
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 stall;
  logic                 flush_e;
  logic [1:0]           branch_d;
  logic                 jump_d;
  logic                 illegal_d;
  logic                 reg_dst_e;
  logic                 alu_src_e;
  logic                 zext_e;
  logic [ALUCTRL_W-1:0] alu_control_e;
  logic                 reg_write_e;
  logic                 mem_to_reg_e;
  logic                 link_e;
  logic                 reg_write_m;
  logic                 mem_to_reg_m;
  logic                 mem_write_m;
  logic                 link_m;
  logic                 reg_write_w;
  logic                 mem_to_reg_w;
  logic                 link_w;
  logic                 illegal_e;
  logic [CNT_W-1:0]     illegal_count;

  modport master (
    output op, funct, stall, flush_e,
    input  branch_d, jump_d, illegal_d,
    input  reg_dst_e, alu_src_e, zext_e, alu_control_e,
    input  reg_write_e, mem_to_reg_e, link_e,
    input  reg_write_m, mem_to_reg_m, mem_write_m, link_m,
    input  reg_write_w, mem_to_reg_w, link_w,
    input  illegal_e, illegal_count
  );

  modport slave (
    input  op, funct, stall, flush_e,
    output branch_d, jump_d, illegal_d,
    output reg_dst_e, alu_src_e, zext_e, alu_control_e,
    output reg_write_e, mem_to_reg_e, link_e,
    output reg_write_m, mem_to_reg_m, mem_write_m, link_m,
    output reg_write_w, mem_to_reg_w, link_w,
    output illegal_e, illegal_count
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control unit: decodes op/funct in ID, drives branch/jump
// there, and carries the remaining controls through ID/EX, EX/MEM and
// MEM/WB registers. Stall, flush and illegal decodes load bubbles into EX;
// issued illegal instructions are counted with a saturating counter.
module pipe_control_unit #(
  parameter int ALUCTRL_W = 3,
  parameter int EXT_OPS   = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  pipe_control_unit_if.slave bus
);

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;
  localparam logic [3:0] A_NOR = 4'b1000;
  localparam logic [3:0] A_XOR = 4'b1001;
  localparam bit         EXT   = (EXT_OPS != 0);
  localparam bit         WIDE  = (ALUCTRL_W == 4);

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 link;
    logic                 reg_dst;
    logic                 alu_src;
    logic                 zext;
    logic [ALUCTRL_W-1:0] alu;
  } ex_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic link;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic link;
  } wb_ctrl_t;

  ex_ctrl_t         w_dec;
  logic [1:0]       w_branch;
  logic             w_jump;
  logic             w_illegal;
  logic             w_rtype;
  ex_ctrl_t         r_ex;
  mem_ctrl_t        r_mem;
  wb_ctrl_t         r_wb;
  logic             r_ille;
  logic [CNT_W-1:0] r_cnt;

  // ID decode; an illegal decode clears every other decode output
  always_comb begin
    w_dec     = '0;
    w_branch  = 2'b00;
    w_jump    = 1'b0;
    w_illegal = 1'b0;
    w_rtype   = 1'b0;
    case (bus.op)
      6'b000000: begin
        case (bus.funct)
          6'b000000: ;
          6'b100000: begin w_rtype = 1'b1; w_dec.alu = A_ADD[ALUCTRL_W-1:0]; end
          6'b100010: begin w_rtype = 1'b1; w_dec.alu = A_SUB[ALUCTRL_W-1:0]; end
          6'b100100: begin w_rtype = 1'b1; w_dec.alu = A_AND[ALUCTRL_W-1:0]; end
          6'b100101: begin w_rtype = 1'b1; w_dec.alu = A_OR[ALUCTRL_W-1:0];  end
          6'b101010: begin w_rtype = 1'b1; w_dec.alu = A_SLT[ALUCTRL_W-1:0]; end
          6'b100111: begin
            w_rtype   = WIDE;
            w_illegal = !WIDE;
            w_dec.alu = A_NOR[ALUCTRL_W-1:0];
          end
          6'b100110: begin
            w_rtype   = WIDE;
            w_illegal = !WIDE;
            w_dec.alu = A_XOR[ALUCTRL_W-1:0];
          end
          default: w_illegal = 1'b1;
        endcase
        if (w_rtype) begin
          w_dec.reg_write = 1'b1;
          w_dec.reg_dst   = 1'b1;
        end
      end
      6'b100011: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.alu        = A_ADD[ALUCTRL_W-1:0];
      end
      6'b101011: begin
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.alu       = A_ADD[ALUCTRL_W-1:0];
      end
      6'b000100: begin
        w_branch  = 2'b01;
        w_dec.alu = A_SUB[ALUCTRL_W-1:0];
      end
      6'b000010: w_jump = 1'b1;
      6'b000101: begin
        w_illegal = !EXT;
        w_branch  = 2'b10;
        w_dec.alu = A_SUB[ALUCTRL_W-1:0];
      end
      6'b001000: begin
        w_illegal       = !EXT;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu       = A_ADD[ALUCTRL_W-1:0];
      end
      6'b001010: begin
        w_illegal       = !EXT;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu       = A_SLT[ALUCTRL_W-1:0];
      end
      6'b001100: begin
        w_illegal       = !EXT;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.zext      = 1'b1;
        w_dec.alu       = A_AND[ALUCTRL_W-1:0];
      end
      6'b001101: begin
        w_illegal       = !EXT;
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.zext      = 1'b1;
        w_dec.alu       = A_OR[ALUCTRL_W-1:0];
      end
      // jal leaves reg_dst at 0; the datapath selects r31 from link
      6'b000011: begin
        w_illegal       = !EXT;
        w_jump          = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.link      = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_dec    = '0;
      w_branch = 2'b00;
      w_jump   = 1'b0;
    end
  end

  // ID-stage outputs are held quiet while reset is asserted
  assign bus.branch_d  = reset ? 2'b00 : w_branch;
  assign bus.jump_d    = reset ? 1'b0  : w_jump;
  assign bus.illegal_d = reset ? 1'b0  : w_illegal;

  // ID/EX: bubble on stall, flush or an undecodable instruction
  always_ff @(posedge clk) begin
    if (reset)                                  r_ex <= '0;
    else if (bus.stall | bus.flush_e | w_illegal) r_ex <= '0;
    else                                        r_ex <= w_dec;
  end

  // EX/MEM and MEM/WB always advance, so a stall never freezes older work
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_mem <= '{reg_write: r_ex.reg_write, mem_to_reg: r_ex.mem_to_reg,
                 mem_write: r_ex.mem_write, link: r_ex.link};
      r_wb  <= '{reg_write: r_mem.reg_write, mem_to_reg: r_mem.mem_to_reg,
                 link: r_mem.link};
    end
  end

  // illegal_e fires only when the illegal instruction actually issues
  always_ff @(posedge clk) begin
    if (reset) r_ille <= 1'b0;
    else       r_ille <= w_illegal & ~bus.stall & ~bus.flush_e;
  end

  // saturating illegal-issue counter, stops at all-ones
  always_ff @(posedge clk) begin
    if (reset)                       r_cnt <= '0;
    else if (r_ille && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.reg_dst_e     = r_ex.reg_dst;
  assign bus.alu_src_e     = r_ex.alu_src;
  assign bus.zext_e        = r_ex.zext;
  assign bus.alu_control_e = r_ex.alu;
  assign bus.reg_write_e   = r_ex.reg_write;
  assign bus.mem_to_reg_e  = r_ex.mem_to_reg;
  assign bus.link_e        = r_ex.link;
  assign bus.reg_write_m   = r_mem.reg_write;
  assign bus.mem_to_reg_m  = r_mem.mem_to_reg;
  assign bus.mem_write_m   = r_mem.mem_write;
  assign bus.link_m        = r_mem.link;
  assign bus.reg_write_w   = r_wb.reg_write;
  assign bus.mem_to_reg_w  = r_wb.mem_to_reg;
  assign bus.link_w        = r_wb.link;
  assign bus.illegal_e     = r_ille;
  assign bus.illegal_count = r_cnt;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit. Two instances share stimulus:
// A = ALUCTRL_W 4 / EXT_OPS 1 / CNT_W 8, B = ALUCTRL_W 3 / EXT_OPS 0 / CNT_W 2.
// Each directed row carries its hand-decoded control word; the stimulus
// pushes per-cycle expectations, the monitor pops and compares.
module tb_pipe_control_unit;

  // control word: rw m2r mw lnk | rdst asrc zx | alu[3:0]
  localparam logic [10:0] C_0    = 11'b0000_000_0000;
  localparam logic [10:0] C_LW   = 11'b1100_010_0010;
  localparam logic [10:0] C_SW   = 11'b0010_010_0010;
  localparam logic [10:0] C_ADD  = 11'b1000_100_0010;
  localparam logic [10:0] C_SUB  = 11'b1000_100_0110;
  localparam logic [10:0] C_AND  = 11'b1000_100_0000;
  localparam logic [10:0] C_OR   = 11'b1000_100_0001;
  localparam logic [10:0] C_SLT  = 11'b1000_100_0111;
  localparam logic [10:0] C_NOR  = 11'b1000_100_1000;
  localparam logic [10:0] C_XOR  = 11'b1000_100_1001;
  localparam logic [10:0] C_ADDI = 11'b1000_010_0010;
  localparam logic [10:0] C_SLTI = 11'b1000_010_0111;
  localparam logic [10:0] C_ANDI = 11'b1000_011_0000;
  localparam logic [10:0] C_ORI  = 11'b1000_011_0001;
  localparam logic [10:0] C_JAL  = 11'b1001_000_0000;
  localparam logic [10:0] C_BR   = 11'b0000_000_0110;

  typedef struct {
    bit          sel;
    logic [1:0]  bd;
    logic        jd;
    logic        ill;
    logic [10:0] e, m, w;
    logic        ie;
    logic [7:0]  cnt;
  } rec_t;

  logic       clk;
  logic       reset;
  logic [5:0] op, funct;
  logic       stall, flush_e;
  rec_t       q[$];
  int         n_pass = 0;
  int         n_tot  = 0;

  logic [10:0] m_e = '0, m_m = '0, m_w = '0;
  logic        m_ie = 1'b0;
  logic [7:0]  m_cnt = '0;

  pipe_control_unit_if #(.ALUCTRL_W(4), .CNT_W(8)) if_a ();
  pipe_control_unit_if #(.ALUCTRL_W(3), .CNT_W(2)) if_b ();

  assign if_a.op = op;  assign if_a.funct = funct;
  assign if_a.stall = stall;  assign if_a.flush_e = flush_e;
  assign if_b.op = op;  assign if_b.funct = funct;
  assign if_b.stall = stall;  assign if_b.flush_e = flush_e;

  pipe_control_unit #(.ALUCTRL_W(4), .EXT_OPS(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .bus(if_a));
  pipe_control_unit #(.ALUCTRL_W(3), .EXT_OPS(0), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
    else n_pass++;
  endtask

  // drive one ID cycle and push what every stage must show after the edge
  task automatic v(input bit s, input bit rst, input bit st, input bit fl,
                   input logic [5:0] o, input logic [5:0] f, input bit ill,
                   input logic [1:0] bd, input bit jd, input logic [10:0] c);
    rec_t       r;
    logic [7:0] mx;
    @(negedge clk);
    reset = rst; stall = st; flush_e = fl; op = o; funct = f;
    mx = s ? 8'd3 : 8'd255;
    r.sel = s;
    r.bd  = rst ? 2'b00 : bd;
    r.jd  = rst ? 1'b0 : jd;
    r.ill = rst ? 1'b0 : ill;
    r.e   = (rst | st | fl | ill) ? C_0 : c;
    r.m   = rst ? C_0 : m_e;
    r.w   = rst ? C_0 : m_m;
    r.ie  = !rst & ill & !st & !fl;
    r.cnt = rst ? 8'd0 : ((m_ie && m_cnt != mx) ? m_cnt + 8'd1 : m_cnt);
    m_e = r.e; m_m = r.m; m_w = r.w; m_ie = r.ie; m_cnt = r.cnt;
    q.push_back(r);
  endtask

  task automatic nops(input bit s, input int n);
    for (int i = 0; i < n; i++) v(s, 0, 0, 0, 6'o00, 6'o00, 0, 2'b00, 0, C_0);
  endtask

  // monitor: ID outputs mid-cycle, registered outputs just after the edge
  initial begin : monitor
    rec_t        r;
    int          idx = 0;
    logic [3:0]  a_id;
    logic [9:0]  a_e;
    logic [3:0]  a_m;
    logic [2:0]  a_w;
    logic        a_ie;
    logic [7:0]  a_cnt;
    forever begin
      @(negedge clk); #3;
      if (q.size() != 0) begin
        r = q.pop_front();
        idx++;
        a_id = r.sel ? {if_b.branch_d, if_b.jump_d, if_b.illegal_d}
                     : {if_a.branch_d, if_a.jump_d, if_a.illegal_d};
        chk($sformatf("id_ctl[%0d]", idx), 16'(a_id), 16'({r.bd, r.jd, r.ill}));
        @(posedge clk); #1;
        if (r.sel) begin
          a_e   = {if_b.reg_write_e, if_b.mem_to_reg_e, if_b.link_e, if_b.reg_dst_e,
                   if_b.alu_src_e, if_b.zext_e, 1'b0, if_b.alu_control_e};
          a_m   = {if_b.reg_write_m, if_b.mem_to_reg_m, if_b.mem_write_m, if_b.link_m};
          a_w   = {if_b.reg_write_w, if_b.mem_to_reg_w, if_b.link_w};
          a_ie  = if_b.illegal_e;
          a_cnt = {6'd0, if_b.illegal_count};
        end else begin
          a_e   = {if_a.reg_write_e, if_a.mem_to_reg_e, if_a.link_e, if_a.reg_dst_e,
                   if_a.alu_src_e, if_a.zext_e, if_a.alu_control_e};
          a_m   = {if_a.reg_write_m, if_a.mem_to_reg_m, if_a.mem_write_m, if_a.link_m};
          a_w   = {if_a.reg_write_w, if_a.mem_to_reg_w, if_a.link_w};
          a_ie  = if_a.illegal_e;
          a_cnt = if_a.illegal_count;
        end
        chk($sformatf("ex_ctl[%0d]", idx), 16'(a_e), 16'({r.e[10:9], r.e[7:0]}));
        chk($sformatf("mem_ctl[%0d]", idx), 16'(a_m), 16'(r.m[10:7]));
        chk($sformatf("wb_ctl[%0d]", idx), 16'(a_w), 16'({r.w[10:9], r.w[7]}));
        chk($sformatf("illegal_e[%0d]", idx), 16'(a_ie), 16'(r.ie));
        chk($sformatf("illegal_count[%0d]", idx), 16'(a_cnt), 16'(r.cnt));
      end
    end
  end

  initial begin : stim
    reset = 1'b1; stall = 1'b0; flush_e = 1'b0; op = '0; funct = '0;
    // ---- instance A ----
    v(0, 1, 0, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    v(0, 1, 0, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    // back-to-back latency
    v(0, 0, 0, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    v(0, 0, 0, 0, 6'b101011, 6'o00, 0, 2'b00, 0, C_SW);
    v(0, 0, 0, 0, 6'b000000, 6'b100000, 0, 2'b00, 0, C_ADD);
    nops(0, 3);
    // stall: add ahead, lw held two cycles
    v(0, 0, 0, 0, 6'b000000, 6'b100000, 0, 2'b00, 0, C_ADD);
    v(0, 0, 1, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    v(0, 0, 1, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    v(0, 0, 0, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    nops(0, 3);
    // full decode sweep
    v(0, 0, 0, 0, 6'b000000, 6'b100111, 0, 2'b00, 0, C_NOR);
    v(0, 0, 0, 0, 6'b000000, 6'b100110, 0, 2'b00, 0, C_XOR);
    v(0, 0, 0, 0, 6'b001101, 6'o00, 0, 2'b00, 0, C_ORI);
    v(0, 0, 0, 0, 6'b000011, 6'o00, 0, 2'b00, 1, C_JAL);
    v(0, 0, 0, 0, 6'b000101, 6'o00, 0, 2'b10, 0, C_BR);
    v(0, 0, 0, 0, 6'b000100, 6'o00, 0, 2'b01, 0, C_BR);
    v(0, 0, 0, 0, 6'b000010, 6'o00, 0, 2'b00, 1, C_0);
    v(0, 0, 0, 0, 6'b001000, 6'o00, 0, 2'b00, 0, C_ADDI);
    v(0, 0, 0, 0, 6'b001010, 6'o00, 0, 2'b00, 0, C_SLTI);
    v(0, 0, 0, 0, 6'b001100, 6'o00, 0, 2'b00, 0, C_ANDI);
    v(0, 0, 0, 0, 6'b000000, 6'b100010, 0, 2'b00, 0, C_SUB);
    v(0, 0, 0, 0, 6'b000000, 6'b100100, 0, 2'b00, 0, C_AND);
    v(0, 0, 0, 0, 6'b000000, 6'b100101, 0, 2'b00, 0, C_OR);
    v(0, 0, 0, 0, 6'b000000, 6'b101010, 0, 2'b00, 0, C_SLT);
    // flush alone and together with stall
    v(0, 0, 0, 1, 6'b000000, 6'b100000, 0, 2'b00, 0, C_ADD);
    v(0, 0, 1, 1, 6'b000000, 6'b100000, 0, 2'b00, 0, C_ADD);
    v(0, 0, 0, 0, 6'b000000, 6'b100000, 0, 2'b00, 0, C_ADD);
    // illegal opcode and illegal funct
    v(0, 0, 0, 0, 6'b111111, 6'o00, 1, 2'b00, 0, C_0);
    v(0, 0, 0, 0, 6'b000000, 6'b000001, 1, 2'b00, 0, C_0);
    nops(0, 3);
    // reset mid-stream discards in-flight controls
    v(0, 0, 0, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    v(0, 0, 0, 0, 6'b101011, 6'o00, 0, 2'b00, 0, C_SW);
    v(0, 1, 0, 0, 6'b000011, 6'o00, 0, 2'b00, 1, C_JAL);
    nops(0, 3);
    // ---- instance B: narrow ALU, no extended ops, 2-bit counter ----
    v(1, 1, 0, 0, 6'o00, 6'o00, 0, 2'b00, 0, C_0);
    v(1, 0, 0, 0, 6'b100011, 6'o00, 0, 2'b00, 0, C_LW);
    v(1, 0, 0, 0, 6'b001000, 6'o00, 1, 2'b00, 0, C_0);
    nops(1, 2);
    v(1, 0, 0, 0, 6'b000000, 6'b100111, 1, 2'b00, 0, C_0);
    // illegal held under stall: counted once on issue
    v(1, 0, 1, 0, 6'b001000, 6'o00, 1, 2'b00, 0, C_0);
    v(1, 0, 1, 0, 6'b001000, 6'o00, 1, 2'b00, 0, C_0);
    v(1, 0, 1, 0, 6'b001000, 6'o00, 1, 2'b00, 0, C_0);
    v(1, 0, 0, 0, 6'b001000, 6'o00, 1, 2'b00, 0, C_0);
    nops(1, 2);
    // more issues drive the counter into saturation
    v(1, 0, 0, 0, 6'b000101, 6'o00, 1, 2'b00, 0, C_0);
    v(1, 0, 0, 0, 6'b000011, 6'o00, 1, 2'b00, 0, C_0);
    v(1, 0, 0, 0, 6'b001101, 6'o00, 1, 2'b00, 0, C_0);
    nops(1, 2);
    v(1, 1, 0, 0, 6'o00, 6'o00, 0, 2'b00, 0, C_0);
    nops(1, 1);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_tot++;
      $display("FAIL drain: %0d records unchecked, want 0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
